line_memory: RTL and testbench

//  Parametrised cache-line backing memory behind the data cache, on the enable/write/ack bus.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/line_memory_array.sv | 26 ++
 rtl/line_memory.sv | 159 +++++++++++++++
 tb/tb_line_memory.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the line memory
package mem_pkg;

  // Request FSM states: idle, waiting out the latency, one-cycle completion
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Width of the latency down-counter; LATENCY is limited to 1..255
  localparam int LAT_W = 8;

  // Ceiling log2 for parameter-time sizing
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/line_memory_array.sv
// rtl/line_memory_array.sv - single-port line-wide storage array
module line_memory_array #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Contents are deliberately not reset; the bench preloads them hierarchically
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port: one whole line per enabled cycle
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[idx_i] <= wdata_i;
  end

  // Read port follows the latched index so the controller can capture it
  // on the same edge it enters ACK
  assign rdata_o = r_mem[idx_i];

endmodule

// File: rtl/line_memory.sv
// rtl/line_memory.sv - latency-modelled cache-line backing memory
module line_memory
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 256,
  parameter int OFFSET_W = 5,
  parameter int DEPTH    = 512,
  parameter int LATENCY  = 10,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  rd_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  localparam int IDX_W    = clog2(DEPTH);
  localparam int HI_SHIFT = OFFSET_W + IDX_W;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LAT_W-1:0]   r_count;
  logic               r_write;
  logic               r_in_range;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [CNT_W-1:0]   r_wr_cnt;

  logic               w_accept;
  logic               w_complete;
  logic               w_ack;
  logic               w_busy;
  logic               w_we;
  logic [IDX_W-1:0]   w_idx;
  logic [ADDR_W-1:0]  w_upper;
  logic               w_in_range;
  logic [DATA_W-1:0]  w_rdata;

  // Address decode: line index plus the bits above it, which must be zero
  assign w_idx      = addr_i[OFFSET_W +: IDX_W];
  assign w_upper    = addr_i >> HI_SHIFT;
  assign w_in_range = (w_upper == '0);

  // State register; reset drops any in-flight request
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and status decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_ack       = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_busy = 1'b1;
        if (r_count == '0) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        w_busy      = 1'b1;
        w_ack       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latency down-counter: loaded at accept so ACK lands LATENCY edges later
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= LAT_W'(LATENCY - 1);
    end else if (r_state == ST_BUSY && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Request latch: captured once at accept, ignored inputs afterwards
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_write    <= write_i;
      r_idx      <= w_idx;
      r_in_range <= w_in_range;
      r_wdata    <= data_i;
    end
  end

  // Write commits on the edge entering ACK, never during reset
  assign w_we = w_complete && r_write && r_in_range && !rst_i;

  line_memory_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_we),
    .idx_i   (r_idx),
    .wdata_i (r_wdata),
    .rdata_o (w_rdata)
  );

  // Read data register: loaded by in-range reads, cleared by range errors,
  // otherwise held across writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
    end else if (w_complete) begin
      if (!r_in_range)   r_data <= '0;
      else if (!r_write) r_data <= w_rdata;
    end
  end

  // Saturating access counters, only for in-range completions
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_complete && r_in_range) begin
      if (r_write) begin
        if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
      end else begin
        if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  assign ack_o    = w_ack;
  assign err_o    = w_ack && !r_in_range;
  assign busy_o   = w_busy;
  assign data_o   = r_data;
  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;

endmodule

// File: tb/tb_line_memory.sv
// tb/tb_line_memory.sv - directed self-checking bench for line_memory
module tb_line_memory;

  logic         clk;
  logic         rst;

  logic         enable, write;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         ack, err, busy;
  logic [255:0] rdata;
  logic [15:0]  rd_cnt, wr_cnt;

  logic         l_enable, l_write;
  logic [31:0]  l_addr;
  logic [255:0] l_wdata;
  logic         l_ack, l_err, l_busy;
  logic [255:0] l_rdata;
  logic [1:0]   l_rd_cnt, l_wr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  line_memory u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .write_i(write),
    .addr_i(addr), .data_i(wdata), .ack_o(ack), .data_o(rdata),
    .err_o(err), .busy_o(busy), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
  );

  line_memory #(.DEPTH(16), .LATENCY(1), .CNT_W(2)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .enable_i(l_enable), .write_i(l_write),
    .addr_i(l_addr), .data_i(l_wdata), .ack_o(l_ack), .data_o(l_rdata),
    .err_o(l_err), .busy_o(l_busy), .rd_cnt_o(l_rd_cnt), .wr_cnt_o(l_wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ack_o is seen; 0 means the budget ran out
  task automatic wait_ack(output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ack) begin
        k = i;
        break;
      end
    end
  endtask

  // Full access from IDLE; reports latency and ack-cycle err/data, ends in IDLE
  task automatic access(input logic wr, input logic [31:0] a, input logic [255:0] d,
                        output int lat, output logic e, output logic [255:0] q);
    int k;
    enable = 1'b1; write = wr; addr = a; wdata = d;
    step();
    wait_ack(k);
    lat = k;
    e = err;
    q = rdata;
    enable = 1'b0;
    step();
  endtask

  initial begin
    int           lat, k, acks;
    logic         e;
    logic [255:0] q;

    rst = 1'b1;
    enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    l_enable = 1'b0; l_write = 1'b0; l_addr = '0; l_wdata = '0;

    u_dut.u_array.r_mem[0]  = 256'h5;
    u_dut.u_array.r_mem[1]  = 256'h77;
    u_dut.u_array.r_mem[32] = 256'h0;
    u_lat1.u_array.r_mem[2] = 256'h33;

    step();
    step();
    rst = 1'b0;

    check("reset_ack",    ack,    1'b0);
    check("reset_err",    err,    1'b0);
    check("reset_busy",   busy,   1'b0);
    check("reset_data",   rdata,  256'h0);
    check("reset_rd_cnt", rd_cnt, 16'd0);
    check("reset_wr_cnt", wr_cnt, 16'd0);

    // 1: read line 0
    enable = 1'b1; write = 1'b0; addr = 32'h0;
    step();
    check("t1_busy_after_accept", busy, 1'b1);
    check("t1_no_early_ack", ack, 1'b0);
    wait_ack(k);
    check("t1_latency", k, 10);
    check("t1_data", rdata, 256'h5);
    check("t1_err", err, 1'b0);
    check("t1_rd_cnt", rd_cnt, 16'd1);
    enable = 1'b0;
    step();
    check("t1_idle_after_ack", busy, 1'b0);

    // 2: write then read line 32
    access(1'b1, 32'h400, 256'hA5, lat, e, q);
    check("t2_wr_latency", lat, 10);
    check("t2_wr_err", e, 1'b0);
    check("t2_wr_data_held", q, 256'h5);
    check("t2_array32", u_dut.u_array.r_mem[32], 256'hA5);
    check("t2_wr_cnt", wr_cnt, 16'd1);
    access(1'b0, 32'h400, '0, lat, e, q);
    check("t2_rd_latency", lat, 10);
    check("t2_rd_data", q, 256'hA5);
    check("t2_rd_cnt", rd_cnt, 16'd2);

    // 3: out-of-range read
    access(1'b0, 32'h4000, '0, lat, e, q);
    check("t3_latency", lat, 10);
    check("t3_err", e, 1'b1);
    check("t3_data_zero", q, 256'h0);
    check("t3_rd_cnt", rd_cnt, 16'd2);
    check("t3_wr_cnt", wr_cnt, 16'd1);

    // 4: inputs changed mid-BUSY are ignored; enable in ACK is not accepted
    enable = 1'b1; write = 1'b0; addr = 32'h400;
    step();
    step();
    step();
    enable = 1'b0; write = 1'b1; addr = 32'h4000; wdata = 256'hFF;
    wait_ack(k);
    check("t4_latency", k + 2, 10);
    check("t4_err", err, 1'b0);
    check("t4_data", rdata, 256'hA5);
    check("t4_rd_cnt", rd_cnt, 16'd3);
    check("t4_array32_intact", u_dut.u_array.r_mem[32], 256'hA5);
    enable = 1'b1; write = 1'b0; addr = 32'h0;
    step();
    check("t4_not_accepted_in_ack", busy, 1'b0);
    wait_ack(k);
    check("t4_next_latency", k - 1, 10);
    check("t4_next_data", rdata, 256'h5);
    check("t4_next_rd_cnt", rd_cnt, 16'd4);
    enable = 1'b0;
    step();

    // 5: reset mid-operation
    acks = 0;
    enable = 1'b1; write = 1'b1; addr = 32'h20; wdata = 256'hDEAD;
    step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack) acks++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy_after_reset", busy, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      if (ack) acks++;
    end
    check("t5_no_ack", acks, 0);
    check("t5_array1_intact", u_dut.u_array.r_mem[1], 256'h77);
    check("t5_wr_cnt", wr_cnt, 16'd0);
    check("t5_rd_cnt", rd_cnt, 16'd0);

    // 6: LATENCY=1, 2-bit counters, five back-to-back reads
    for (int r = 0; r < 5; r++) begin
      l_enable = 1'b1; l_write = 1'b0; l_addr = 32'h40;
      step();
      check($sformatf("t6_busy_%0d", r), l_busy, 1'b1);
      check($sformatf("t6_no_ack_%0d", r), l_ack, 1'b0);
      step();
      check($sformatf("t6_ack_%0d", r), l_ack, 1'b1);
      check($sformatf("t6_data_%0d", r), l_rdata, 256'h33);
      check($sformatf("t6_rd_cnt_%0d", r), l_rd_cnt, (r < 3) ? 2'(r + 1) : 2'd3);
      l_enable = 1'b0;
      step();
    end
    check("t6_err", l_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
